// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads one- or two-word instructions from the
// unified program/data memory and presents them to the decoder over a
// valid/ready handshake. Execute can stall the port (bus_gnt) and redirect the PC.
module instr_fetch #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int START_PC   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  input  logic                  bus_gnt,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_w0,
  output logic [DATA_WIDTH-1:0] instr_w1,
  output logic                  instr_two,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH0 = 2'd1;
  localparam logic [1:0] FETCH1 = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] PC_RESET = ADDR_WIDTH'(START_PC);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE   = ADDR_WIDTH'(1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] w0_q, w0_d;
  logic [DATA_WIDTH-1:0] w1_q, w1_d;
  logic                  two_q, two_d;
  logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
  logic                  valid_q, valid_d;

  logic [3:0] opc;
  logic       rdata_two;

  // Two-word decode of the word currently on the read bus
  always_comb begin
    opc       = mem_rdata[DATA_WIDTH-1 -: 4];
    rdata_two = (opc == 4'h8) || (opc == 4'h9) || ((opc == 4'h0) && mem_rdata[3]);
  end

  // Next-state logic; redirect overrides every state, including a grant or handshake
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    two_d   = two_q;
    ipc_d   = ipc_q;
    if (redirect_valid) begin
      pc_d    = redirect_addr;
      state_d = fetch_en ? FETCH0 : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_en) state_d = FETCH0;
        end
        FETCH0: begin
          if (bus_gnt) begin
            w0_d    = mem_rdata;
            ipc_d   = pc_q;
            pc_d    = pc_q + PC_ONE;
            w1_d    = '0;
            two_d   = 1'b0;
            state_d = rdata_two ? FETCH1 : HOLD;
          end
        end
        FETCH1: begin
          if (bus_gnt) begin
            w1_d    = mem_rdata;
            two_d   = 1'b1;
            pc_d    = pc_q + PC_ONE;
            state_d = HOLD;
          end
        end
        default: begin
          if (instr_ready) state_d = fetch_en ? FETCH0 : IDLE;
        end
      endcase
    end
    valid_d = (state_d == HOLD);
  end

  // State and instruction registers, asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= PC_RESET;
      w0_q    <= '0;
      w1_q    <= '0;
      two_q   <= 1'b0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      two_q   <= two_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  // Port request decoded from state only; address follows the PC register
  always_comb begin
    mem_rd      = (state_q == FETCH0) || (state_q == FETCH1);
    mem_addr    = pc_q;
    instr_valid = valid_q;
    instr_w0    = w0_q;
    instr_w1    = w1_q;
    instr_two   = two_q;
    instr_pc    = ipc_q;
  end

endmodule
